// File: rtl/board_input_controller.sv
// board_input_controller: front-panel input stage for the whack-a-mole board.
// Debounces the four direction buttons and ROT_CENTER, filters and decodes the
// ROT_A/ROT_B quadrature encoder, and keeps the 4x4 cursor (oCell = row*4+col).
// Build option: define BOARD_WRAP_EN to make button moves wrap within the
// row/column instead of saturating at the grid edge.
module board_input_controller #(
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int ROT_FILTER_CYCLES = 1000,
  parameter int CNT_W             = 20
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       BTN_NORTH,
  input  logic       BTN_SOUTH,
  input  logic       BTN_EAST,
  input  logic       BTN_WEST,
  input  logic       ROT_CENTER,
  input  logic       ROT_A,
  input  logic       ROT_B,
  output logic [3:0] oCell,
  output logic       oMoved,
  output logic       oEnter,
  output logic       oDropped
);
  // Input bit order: 0 north, 1 south, 2 east, 3 west, 4 center, 5 A, 6 B.
  // Bits below NBTN use the button debounce length, the rest the rotary filter.
  localparam int NIN  = 7;
  localparam int NBTN = 5;
  localparam logic [CNT_W-1:0] BTN_LIM = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ROT_LIM = CNT_W'(ROT_FILTER_CYCLES - 1);

  logic [NIN-1:0]            raw, sync1, sync2, deb, deb_n;
  logic [NIN-1:0][CNT_W-1:0] cnt, cnt_n;
  logic [5:0]                press;    // registered rising edges of deb[5:0]
  logic                      rot_ccw;  // filtered B level alongside press[5]
  logic [1:0]                row, col;
  logic [4:0]                moves;
  logic                      dropped_n;
  logic [3:0]                cell_n;

  assign raw = {ROT_B, ROT_A, ROT_CENTER, BTN_WEST, BTN_EAST, BTN_SOUTH, BTN_NORTH};

  // Two-flop synchronizer on every raw input
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Stability counters: a level changes only after LIM+1 consecutive
  // disagreeing samples; any agreeing sample restarts the count
  always_comb begin
    deb_n = deb;
    cnt_n = '0;
    for (int i = 0; i < NIN; i++) begin
      if (sync2[i] != deb[i]) begin
        if (cnt[i] == ((i < NBTN) ? BTN_LIM : ROT_LIM)) deb_n[i] = sync2[i];
        else                                            cnt_n[i] = cnt[i] + CNT_W'(1);
      end
    end
  end

  // Debounced levels, counters and one-cycle press strobes
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      deb     <= '0;
      cnt     <= '0;
      press   <= '0;
      rot_ccw <= 1'b0;
    end else begin
      deb     <= deb_n;
      cnt     <= cnt_n;
      press   <= deb_n[5:0] & ~deb[5:0];
      rot_ccw <= deb[6];
    end
  end

  // Enter is a pure strobe; it leaves the board one cycle ahead of any
  // move raised in the same cycle, so the board sees the old cell with it.
  assign oEnter = press[4];

  assign row   = oCell[3:2];
  assign col   = oCell[1:0];
  assign moves = {press[5], press[3:0]};
  // More than one move candidate this cycle: all but the winner are lost
  assign dropped_n = |(moves & (moves - 5'd1));

  // Priority move select: north > south > east > west > rotary
  always_comb begin
    cell_n = oCell;
    if (press[0]) begin
`ifdef BOARD_WRAP_EN
      cell_n = {row - 2'd1, col};
`else
      cell_n = {(row == 2'd0) ? row : row - 2'd1, col};
`endif
    end else if (press[1]) begin
`ifdef BOARD_WRAP_EN
      cell_n = {row + 2'd1, col};
`else
      cell_n = {(row == 2'd3) ? row : row + 2'd1, col};
`endif
    end else if (press[2]) begin
`ifdef BOARD_WRAP_EN
      cell_n = {row, col - 2'd1};
`else
      cell_n = {row, (col == 2'd0) ? col : col - 2'd1};
`endif
    end else if (press[3]) begin
`ifdef BOARD_WRAP_EN
      cell_n = {row, col + 2'd1};
`else
      cell_n = {row, (col == 2'd3) ? col : col + 2'd1};
`endif
    end else if (press[5]) begin
      // Rotary steps walk the linear index and wrap mod 16 in both builds
      cell_n = rot_ccw ? oCell - 4'd1 : oCell + 4'd1;
    end
  end

  // Cursor register plus moved/dropped strobes
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      oCell    <= '0;
      oMoved   <= 1'b0;
      oDropped <= 1'b0;
    end else begin
      oCell    <= cell_n;
      oMoved   <= (cell_n != oCell);
      oDropped <= dropped_n;
    end
  end

endmodule

// File: tb/tb_board_input_controller.sv
// tb_board_input_controller: directed and random stimulus against a window-based
// behavioural model of the input stage (small debounce lengths).
module tb_board_input_controller;
  localparam int DB = 4;
  localparam int RF = 2;
`ifdef BOARD_WRAP_EN
  localparam int NORTH_CELL = 12;
  localparam int NORTH_MV   = 1;
`else
  localparam int NORTH_CELL = 0;
  localparam int NORTH_MV   = 0;
`endif
  localparam logic [6:0] V_N = 7'b0000001;
  localparam logic [6:0] V_S = 7'b0000010;
  localparam logic [6:0] V_W = 7'b0001000;
  localparam logic [6:0] V_C = 7'b0010000;
  localparam logic [6:0] V_A = 7'b0100000;
  localparam logic [6:0] V_B = 7'b1000000;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       BTN_NORTH = 0, BTN_SOUTH = 0, BTN_EAST = 0, BTN_WEST = 0;
  logic       ROT_CENTER = 0, ROT_A = 0, ROT_B = 0;
  logic [3:0] oCell;
  logic       oMoved, oEnter, oDropped;

  board_input_controller #(.DEBOUNCE_CYCLES(DB), .ROT_FILTER_CYCLES(RF), .CNT_W(20)) dut (
    .Clock(Clock), .Reset(Reset),
    .BTN_NORTH(BTN_NORTH), .BTN_SOUTH(BTN_SOUTH), .BTN_EAST(BTN_EAST), .BTN_WEST(BTN_WEST),
    .ROT_CENTER(ROT_CENTER), .ROT_A(ROT_A), .ROT_B(ROT_B),
    .oCell(oCell), .oMoved(oMoved), .oEnter(oEnter), .oDropped(oDropped)
  );

  always #5 Clock = ~Clock;

  int vectors = 0;
  int miscompares = 0;
  int n_moved, n_drop;

  // Model: raw sample history per input, debounced levels, strobes, cursor
  logic [6:0] rawv = '0;
  bit         hist [7][16];
  bit   [6:0] m_deb;
  bit   [5:0] m_ev;
  bit         m_ccw;
  int         m_cell;
  bit         m_moved, m_drop;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int edge_fix(input int v);
`ifdef BOARD_WRAP_EN
    return (v + 4) % 4;
`else
    return (v < 0) ? 0 : ((v > 3) ? 3 : v);
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 7; i++) for (int j = 0; j < 16; j++) hist[i][j] = 1'b0;
    m_deb = '0; m_ev = '0; m_ccw = 1'b0;
    m_cell = 0; m_moved = 1'b0; m_drop = 1'b0;
  endtask

  // One clock edge of the model. hist[i][1..lim] are the synchronized samples
  // the debouncer sees this edge; a level flips when all of them disagree.
  task automatic model_edge();
    bit [6:0] dn;
    int r, c, nc, nm;
    r  = m_cell / 4;
    c  = m_cell % 4;
    nc = m_cell;
    nm = int'(m_ev[0]) + int'(m_ev[1]) + int'(m_ev[2]) + int'(m_ev[3]) + int'(m_ev[5]);
    if      (m_ev[0]) nc = 4 * edge_fix(r - 1) + c;
    else if (m_ev[1]) nc = 4 * edge_fix(r + 1) + c;
    else if (m_ev[2]) nc = 4 * r + edge_fix(c - 1);
    else if (m_ev[3]) nc = 4 * r + edge_fix(c + 1);
    else if (m_ev[5]) nc = (m_cell + (m_ccw ? 15 : 1)) % 16;
    m_moved = (nc != m_cell);
    m_drop  = (nm > 1);
    for (int i = 0; i < 7; i++) begin
      int lim;
      bit all;
      lim = (i < 5) ? DB : RF;
      all = 1'b1;
      for (int j = 1; j <= lim; j++) if (hist[i][j] == m_deb[i]) all = 1'b0;
      dn[i] = all ? ~m_deb[i] : m_deb[i];
    end
    m_ccw  = m_deb[6];
    m_ev   = dn[5:0] & ~m_deb[5:0];
    m_deb  = dn;
    m_cell = nc;
    for (int i = 0; i < 7; i++) begin
      for (int j = 15; j > 0; j--) hist[i][j] = hist[i][j-1];
      hist[i][0] = rawv[i];
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    if (!Reset) model_edge();
    @(negedge Clock);
    chk("cell",    32'(oCell),    32'(m_cell));
    chk("moved",   32'(oMoved),   32'(m_moved));
    chk("enter",   32'(oEnter),   32'(m_ev[4]));
    chk("dropped", 32'(oDropped), 32'(m_drop));
    n_moved += int'(oMoved);
    n_drop  += int'(oDropped);
  endtask

  task automatic set_in(input logic [6:0] v);
    rawv = v;
    {ROT_B, ROT_A, ROT_CENTER, BTN_WEST, BTN_EAST, BTN_SOUTH, BTN_NORTH} = v;
  endtask

  task automatic drive(input logic [6:0] v, input int n);
    set_in(v);
    repeat (n) tick();
  endtask

  task automatic clr();
    n_moved = 0;
    n_drop  = 0;
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once
  task automatic do_reset();
    #2 Reset = 1'b1;
    model_reset();
    #1;
    chk("arst_cell",   32'(oCell), 0);
    chk("arst_pulses", 32'({oMoved, oEnter, oDropped}), 0);
    tick();
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    int at, found;
    logic [6:0] v;
    model_reset();
    clr();
    drive('0, 3);
    Reset = 1'b0;
    chk("rst_cell",    32'(oCell),    0);
    chk("rst_moved",   32'(oMoved),   0);
    chk("rst_enter",   32'(oEnter),   0);
    chk("rst_dropped", 32'(oDropped), 0);

    // West held: one move, seven edges after the raw rise
    clr();
    at = 0;
    set_in(V_W);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (at == 0 && oCell != 4'd0) at = i;
    end
    chk("west_latency", at, 7);
    chk("west_cell", 32'(oCell), 1);
    chk("west_moves", n_moved, 1);
    drive('0, 10);

    // Three-cycle glitch is filtered out
    clr();
    drive(V_W, 3);
    drive('0, 12);
    chk("glitch_cell", 32'(oCell), 1);
    chk("glitch_moves", n_moved, 0);

    // North from row 0
    do_reset();
    clr();
    drive(V_N, 10);
    drive('0, 10);
    chk("north_cell", 32'(oCell), NORTH_CELL);
    chk("north_moves", n_moved, NORTH_MV);

    // North and west together from cell 5
    do_reset();
    drive(V_W, 10); drive('0, 10);
    drive(V_S, 10); drive('0, 10);
    chk("pre5_cell", 32'(oCell), 5);
    clr();
    drive(V_N | V_W, 10);
    drive('0, 10);
    chk("nw_cell", 32'(oCell), 1);
    chk("nw_drops", n_drop, 1);
    chk("nw_moves", n_moved, 1);

    // Enter with south from cell 2: enter sees old cell, move lands next cycle
    do_reset();
    drive(V_W, 10); drive('0, 10);
    drive(V_W, 10); drive('0, 10);
    chk("pre2_cell", 32'(oCell), 2);
    set_in(V_C | V_S);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (oEnter && found == 0) begin
        found = 1;
        chk("enter_cell", 32'(oCell), 2);
        tick();
        chk("enter_next_cell", 32'(oCell), 6);
        chk("enter_next_moved", 32'(oMoved), 1);
      end
    end
    chk("enter_seen", found, 1);
    drive('0, 10);

    // Rotary: CCW from 0 wraps to 15, CW from 15 wraps to 0, then CCW again
    do_reset();
    drive(V_B, 5); drive(V_A | V_B, 5); drive(V_B, 5); drive('0, 5);
    chk("ccw_wrap", 32'(oCell), 15);
    drive(V_A, 5); drive('0, 5);
    chk("cw_wrap", 32'(oCell), 0);
    drive(V_B, 5); drive(V_A | V_B, 5); drive(V_B, 5); drive('0, 5);
    chk("ccw_again", 32'(oCell), 15);

    // Reset mid-debounce with the button still held: exactly one move after
    do_reset();
    drive(V_W, 3);
    do_reset();
    clr();
    drive(V_W, 15);
    drive('0, 10);
    chk("held_cell", 32'(oCell), 1);
    chk("held_moves", n_moved, 1);

    // Random toggling with occasional resets
    v = '0;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 7; i++) if ($urandom_range(7) == 0) v[i] = ~v[i];
      drive(v, 1);
      if ($urandom_range(499) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
